// File: rtl/cc_rowsrc_mux_if.sv
// Bus bundle for cc_rowsrc_mux: select/load/blink/tick/data in, row/valid/error out.
interface cc_rowsrc_mux_if #(
    parameter int DATAWIDTH = 8,
    parameter int SELWIDTH  = 8,
    parameter int NUM_CH    = 2
);
    logic [SELWIDTH-1:0]         CC_ROWSRC_select_InBUS;
    logic                        CC_ROWSRC_load_In;
    logic                        CC_ROWSRC_blink_In;
    logic                        CC_ROWSRC_tick_In;
    logic [NUM_CH*DATAWIDTH-1:0] CC_ROWSRC_data_InBUS;
    logic [DATAWIDTH-1:0]        CC_ROWSRC_z_OutBus;
    logic                        CC_ROWSRC_valid_Out;
    logic                        CC_ROWSRC_selerr_Out;

    modport master (
        output CC_ROWSRC_select_InBUS, CC_ROWSRC_load_In, CC_ROWSRC_blink_In,
               CC_ROWSRC_tick_In, CC_ROWSRC_data_InBUS,
        input  CC_ROWSRC_z_OutBus, CC_ROWSRC_valid_Out, CC_ROWSRC_selerr_Out
    );

    modport slave (
        input  CC_ROWSRC_select_InBUS, CC_ROWSRC_load_In, CC_ROWSRC_blink_In,
               CC_ROWSRC_tick_In, CC_ROWSRC_data_InBUS,
        output CC_ROWSRC_z_OutBus, CC_ROWSRC_valid_Out, CC_ROWSRC_selerr_Out
    );
endinterface

// File: rtl/cc_rowsrc_mux.sv
// Registered row-source selector: CLEAR / FILL / NUM_CH channels, latched on load.
// Tick-driven blink mode is built only when CC_ROWSRC_BLINK_EN is defined.
module cc_rowsrc_mux #(
    parameter int DATAWIDTH    = 8,
    parameter int SELWIDTH     = 8,
    parameter int NUM_CH       = 2,
    parameter int BLINK_PERIOD = 25
) (
    input  logic                CC_ROWSRC_CLOCK_50,
    input  logic                CC_ROWSRC_RESET_InLow,
    cc_rowsrc_mux_if.slave      bus
);
    localparam int NSRC_W = SELWIDTH + 1;
    localparam logic [NSRC_W-1:0]   NUM_SRC  = NSRC_W'(NUM_CH + 2);
    localparam logic [SELWIDTH-1:0] SEL_CLEAR = SELWIDTH'(0);
    localparam logic [SELWIDTH-1:0] SEL_FILL  = SELWIDTH'(1);

    logic                 clk;
    logic                 rst_n;
    logic [SELWIDTH-1:0]  sel_r;
    logic                 pending_r;
    logic                 valid_r;
    logic                 selerr_r;
    logic [DATAWIDTH-1:0] z_r;
    logic                 sel_ok_s;
    logic                 load_ok_s;
    logic                 blank_s;
    logic [DATAWIDTH-1:0] src_s;

    assign clk       = CC_ROWSRC_CLOCK_50;
    assign rst_n     = CC_ROWSRC_RESET_InLow;
    assign sel_ok_s  = ({1'b0, bus.CC_ROWSRC_select_InBUS} < NUM_SRC);
    assign load_ok_s = bus.CC_ROWSRC_load_In & sel_ok_s;

    // Source mux driven by the latched select, never by the live select bus.
    always_comb begin
        src_s = {DATAWIDTH{1'b0}};
        if (sel_r == SEL_CLEAR) begin
            src_s = {DATAWIDTH{1'b0}};
        end else if (sel_r == SEL_FILL) begin
            src_s = {DATAWIDTH{1'b1}};
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                src_s = (sel_r == SELWIDTH'(k + 2))
                      ? bus.CC_ROWSRC_data_InBUS[k*DATAWIDTH +: DATAWIDTH]
                      : src_s;
            end
        end
    end

    // Select latch, load-done pipeline and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r     <= SELWIDTH'(0);
            pending_r <= 1'b0;
            valid_r   <= 1'b0;
            selerr_r  <= 1'b0;
        end else begin
            valid_r <= pending_r;
            if (load_ok_s) begin
                sel_r     <= bus.CC_ROWSRC_select_InBUS;
                pending_r <= 1'b1;
                selerr_r  <= 1'b0;
            end else if (bus.CC_ROWSRC_load_In) begin
                pending_r <= 1'b0;
                selerr_r  <= 1'b1;
            end else begin
                pending_r <= 1'b0;
            end
        end
    end

`ifdef CC_ROWSRC_BLINK_EN
    localparam int CNT_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_PERIOD - 1);

    logic             blink_r;
    logic             phase_r;
    logic [CNT_W-1:0] cnt_r;

    // Blink time base; a valid load restarts it and swallows a coincident tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_r <= 1'b0;
            phase_r <= 1'b0;
            cnt_r   <= CNT_W'(0);
        end else if (load_ok_s) begin
            blink_r <= bus.CC_ROWSRC_blink_In;
            phase_r <= 1'b0;
            cnt_r   <= CNT_W'(0);
        end else if (bus.CC_ROWSRC_load_In) begin
            blink_r <= blink_r;
        end else if (blink_r && bus.CC_ROWSRC_tick_In) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r   <= CNT_W'(0);
                phase_r <= ~phase_r;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign blank_s = blink_r & phase_r;
`else
    assign blank_s = 1'b0;
`endif

    // Output row register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_r <= {DATAWIDTH{1'b0}};
        end else if (blank_s) begin
            z_r <= {DATAWIDTH{1'b0}};
        end else begin
            z_r <= src_s;
        end
    end

    assign bus.CC_ROWSRC_z_OutBus   = z_r;
    assign bus.CC_ROWSRC_valid_Out  = valid_r;
    assign bus.CC_ROWSRC_selerr_Out = selerr_r;
endmodule

// File: tb/tb_cc_rowsrc_mux.sv
// Scoreboard bench for cc_rowsrc_mux (NUM_CH=2, BLINK_PERIOD=2); blink expectations follow CC_ROWSRC_BLINK_EN.
module tb_cc_rowsrc_mux;
    localparam int DW = 8;
    localparam int SW = 8;
    localparam int NC = 2;

    typedef struct packed {
        logic [7:0] z;
        logic       v;
        logic       e;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    cc_rowsrc_mux_if #(.DATAWIDTH(DW), .SELWIDTH(SW), .NUM_CH(NC)) bus ();

    cc_rowsrc_mux #(.DATAWIDTH(DW), .SELWIDTH(SW), .NUM_CH(NC), .BLINK_PERIOD(2)) dut (
        .CC_ROWSRC_CLOCK_50    (clk),
        .CC_ROWSRC_RESET_InLow (rst_n),
        .bus                   (bus)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus from a falling edge and return at the next falling edge.
    task automatic drive(input logic [7:0] sel, input logic ld, input logic bl, input logic tk);
        bus.CC_ROWSRC_select_InBUS = sel;
        bus.CC_ROWSRC_load_In      = ld;
        bus.CC_ROWSRC_blink_In     = bl;
        bus.CC_ROWSRC_tick_In      = tk;
        @(posedge clk);
        @(negedge clk);
        bus.CC_ROWSRC_load_In = 1'b0;
        bus.CC_ROWSRC_tick_In = 1'b0;
    endtask

    task automatic test_reset();
        exp_t got;
        #3;
        got = {bus.CC_ROWSRC_z_OutBus, bus.CC_ROWSRC_valid_Out, bus.CC_ROWSRC_selerr_Out};
        n_checks++;
        if (got !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_state: got z=%h v=%b e=%b, want z=00 v=0 e=0", got.z, got.v, got.e);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill_clear();
        logic [7:0] sel_t [6] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        logic       ld_t  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_t       ex_t  [6] = '{{8'h00,1'b0,1'b0}, {8'hFF,1'b1,1'b0}, {8'hFF,1'b0,1'b0},
                                  {8'hFF,1'b0,1'b0}, {8'h00,1'b1,1'b0}, {8'h00,1'b0,1'b0}};
        exp_t e, got;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(ex_t[i]);
            drive(sel_t[i], ld_t[i], 1'b0, 1'b0);
            e = exp_q.pop_front();
            got = {bus.CC_ROWSRC_z_OutBus, bus.CC_ROWSRC_valid_Out, bus.CC_ROWSRC_selerr_Out};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL fill_clear[%0d]: got z=%h v=%b e=%b, want z=%h v=%b e=%b",
                         i, got.z, got.v, got.e, e.z, e.v, e.e);
            end
        end
    endtask

    task automatic test_channels();
        logic [7:0]  sel_t [7] = '{8'd2, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0};
        logic        ld_t  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0] dat_t [7] = '{16'hA53C, 16'hA53C, 16'hA511, 16'hA53C, 16'hA53C, 16'hA53C, 16'hA53C};
        exp_t        ex_t  [7] = '{{8'h00,1'b0,1'b0}, {8'h3C,1'b1,1'b0}, {8'h11,1'b0,1'b0},
                                   {8'h3C,1'b0,1'b0}, {8'h3C,1'b0,1'b0}, {8'hA5,1'b1,1'b0},
                                   {8'hA5,1'b0,1'b0}};
        exp_t e, got;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(ex_t[i]);
            bus.CC_ROWSRC_data_InBUS = dat_t[i];
            drive(sel_t[i], ld_t[i], 1'b0, 1'b0);
            e = exp_q.pop_front();
            got = {bus.CC_ROWSRC_z_OutBus, bus.CC_ROWSRC_valid_Out, bus.CC_ROWSRC_selerr_Out};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL channels[%0d]: got z=%h v=%b e=%b, want z=%h v=%b e=%b",
                         i, got.z, got.v, got.e, e.z, e.v, e.e);
            end
        end
    endtask

    task automatic test_invalid();
        logic [7:0] sel_t [8] = '{8'd2, 8'd0, 8'd9, 8'd4, 8'd0, 8'd1, 8'd0, 8'd0};
        logic       ld_t  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_t       ex_t  [8] = '{{8'hA5,1'b0,1'b0}, {8'h3C,1'b1,1'b0}, {8'h3C,1'b0,1'b1},
                                  {8'h3C,1'b0,1'b1}, {8'h3C,1'b0,1'b1}, {8'h3C,1'b0,1'b0},
                                  {8'hFF,1'b1,1'b0}, {8'hFF,1'b0,1'b0}};
        exp_t e, got;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(ex_t[i]);
            drive(sel_t[i], ld_t[i], 1'b0, 1'b0);
            e = exp_q.pop_front();
            got = {bus.CC_ROWSRC_z_OutBus, bus.CC_ROWSRC_valid_Out, bus.CC_ROWSRC_selerr_Out};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL invalid_sel[%0d]: got z=%h v=%b e=%b, want z=%h v=%b e=%b",
                         i, got.z, got.v, got.e, e.z, e.v, e.e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] sel_t [5] = '{8'd0, 8'd2, 8'd1, 8'd0, 8'd0};
        logic       ld_t  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_t       ex_t  [5] = '{{8'hFF,1'b0,1'b0}, {8'h00,1'b1,1'b0}, {8'h3C,1'b1,1'b0},
                                  {8'hFF,1'b1,1'b0}, {8'hFF,1'b0,1'b0}};
        exp_t e, got;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(ex_t[i]);
            drive(sel_t[i], ld_t[i], 1'b0, 1'b0);
            e = exp_q.pop_front();
            got = {bus.CC_ROWSRC_z_OutBus, bus.CC_ROWSRC_valid_Out, bus.CC_ROWSRC_selerr_Out};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got z=%h v=%b e=%b, want z=%h v=%b e=%b",
                         i, got.z, got.v, got.e, e.z, e.v, e.e);
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [7:0] sel_t [4] = '{8'd0, 8'd1, 8'd0, 8'd0};
        logic       ld_t  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        exp_t       ex_t  [4] = '{{8'h00,1'b0,1'b0}, {8'h00,1'b0,1'b0}, {8'hFF,1'b1,1'b0},
                                  {8'hFF,1'b0,1'b0}};
        exp_t e, got;
        bus.CC_ROWSRC_select_InBUS = 8'd2;
        bus.CC_ROWSRC_load_In      = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        got = {bus.CC_ROWSRC_z_OutBus, bus.CC_ROWSRC_valid_Out, bus.CC_ROWSRC_selerr_Out};
        n_checks++;
        if (got !== 10'h000) begin
            n_fail++;
            $display("FAIL async_reset: got z=%h v=%b e=%b, want z=00 v=0 e=0", got.z, got.v, got.e);
        end
        @(negedge clk);
        bus.CC_ROWSRC_load_In = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ex_t[i]);
            drive(sel_t[i], ld_t[i], 1'b0, 1'b0);
            e = exp_q.pop_front();
            got = {bus.CC_ROWSRC_z_OutBus, bus.CC_ROWSRC_valid_Out, bus.CC_ROWSRC_selerr_Out};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: got z=%h v=%b e=%b, want z=%h v=%b e=%b",
                         i, got.z, got.v, got.e, e.z, e.v, e.e);
            end
        end
    endtask

    task automatic test_blink();
        logic       ld_t [11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef CC_ROWSRC_BLINK_EN
        logic [7:0] z_t  [11] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00,
                                  8'hFF, 8'hFF, 8'h00};
`else
        logic [7:0] z_t  [11] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                  8'hFF, 8'hFF, 8'hFF};
`endif
        logic       v_t  [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_t e, got;
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back({z_t[i], v_t[i], 1'b0});
            drive(8'd1, ld_t[i], 1'b1, 1'b1);
            e = exp_q.pop_front();
            got = {bus.CC_ROWSRC_z_OutBus, bus.CC_ROWSRC_valid_Out, bus.CC_ROWSRC_selerr_Out};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL blink[%0d]: got z=%h v=%b e=%b, want z=%h v=%b e=%b",
                         i, got.z, got.v, got.e, e.z, e.v, e.e);
            end
        end
    endtask

    initial begin
        bus.CC_ROWSRC_select_InBUS = 8'd0;
        bus.CC_ROWSRC_load_In      = 1'b0;
        bus.CC_ROWSRC_blink_In     = 1'b0;
        bus.CC_ROWSRC_tick_In      = 1'b0;
        bus.CC_ROWSRC_data_InBUS   = 16'hA53C;
        test_reset();
        test_fill_clear();
        test_channels();
        test_invalid();
        test_back_to_back();
        test_reset_midop();
        test_blink();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
